// File: rtl/ddr5_cmd_scheduler_if.sv
// rtl/ddr5_cmd_scheduler_if.sv - request-queue / DRAM command-bus bundle for ddr5_cmd_scheduler
interface ddr5_cmd_scheduler_if;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [33:0] req_addr;
  logic        req_ready;
  logic        cmd_valid;
  logic [2:0]  cmd_type;
  logic [2:0]  cmd_bg;
  logic [1:0]  cmd_ba;
  logic [15:0] cmd_row;
  logic [9:0]  cmd_col;
  logic        done;
  logic [1:0]  done_op;

  modport master (
    output req_valid, req_op, req_addr,
    input  req_ready, cmd_valid, cmd_type, cmd_bg, cmd_ba, cmd_row, cmd_col, done, done_op
  );

  modport slave (
    input  req_valid, req_op, req_addr,
    output req_ready, cmd_valid, cmd_type, cmd_bg, cmd_ba, cmd_row, cmd_col, done, done_op
  );
endinterface

// File: rtl/ddr5_cmd_scheduler.sv
// rtl/ddr5_cmd_scheduler.sv - in-order DDR5 PRE/ACT/CAS sequencer with per-bank open-row tracking
// Define CLOSED_PAGE_EN for the auto-precharge (RDA/WRA) closed-page policy.
module ddr5_cmd_scheduler #(
  parameter int T_RCD   = 39,
  parameter int T_RP    = 39,
  parameter int T_RAS   = 76,
  parameter int T_CL    = 40,
  parameter int T_CWL   = 38,
  parameter int T_BURST = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  ddr5_cmd_scheduler_if.slave bus_io
);

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_PRE = 3'd2;
`ifdef CLOSED_PAGE_EN
  localparam logic [2:0] CMD_RD  = 3'd5;
  localparam logic [2:0] CMD_WR  = 3'd6;
  localparam int         DATA_EXTRA = T_RP;
`else
  localparam logic [2:0] CMD_RD  = 3'd3;
  localparam logic [2:0] CMD_WR  = 3'd4;
  localparam int         DATA_EXTRA = 0;
`endif

  localparam int RD_SUM = T_CL + T_BURST + DATA_EXTRA;
  localparam int WR_SUM = T_CWL + T_BURST + DATA_EXTRA;

  localparam logic [7:0] RP_LOAD  = 8'(T_RP - 1);
  localparam logic [7:0] RCD_LOAD = 8'(T_RCD - 1);
  localparam logic [7:0] RD_LOAD  = 8'(RD_SUM - 1);
  localparam logic [7:0] WR_LOAD  = 8'(WR_SUM - 1);
  localparam logic [7:0] RAS_LOAD = 8'(T_RAS);

  if (T_RCD < 1 || T_RCD > 255 || T_RP < 1 || T_RP > 255 || T_RAS < 0 || T_RAS > 255 ||
      T_BURST < 1 || RD_SUM > 255 || WR_SUM > 255 || T_CL + T_BURST + T_RP > 255) begin : g_param_check
    $error("ddr5_cmd_scheduler: timing parameters do not fit the 8-bit counters");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_PRE, S_ACT, S_CAS, S_WAIT_RP, S_WAIT_RCD, S_WAIT_DATA
  } state_e;

  state_e       state_q, state_d;
  logic [7:0]   wait_q, wait_d;
  logic [1:0]   op_q;
  logic [2:0]   bg_q;
  logic [1:0]   ba_q;
  logic [15:0]  row_q;
  logic [9:0]   col_q;
  logic [31:0]  open_q;
  logic [15:0]  row_tab_q [32];
  logic [7:0]   tras_q    [32];

  logic         req_ready_q;
  logic         cmd_valid_q;
  logic [2:0]   cmd_type_q;
  logic [2:0]   cmd_bg_q;
  logic [1:0]   cmd_ba_q;
  logic [15:0]  cmd_row_q;
  logic [9:0]   cmd_col_q;
  logic         done_q;
  logic [1:0]   done_op_q;

  logic         accept;
  logic         do_pre, do_act, do_cas, fin;
  logic [4:0]   bank;
  logic         unused_addr;

  assign accept      = (state_q == S_IDLE) && req_ready_q && bus_io.req_valid;
  assign bank        = {bg_q, ba_q};
  assign unused_addr = ^{bus_io.req_addr[6], bus_io.req_addr[1:0]};

  // Commands leaving a wait state are issued on the same edge the counter is seen at zero,
  // so ACT->CAS and PRE->ACT spacing equals the timing parameter exactly.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    do_pre  = 1'b0;
    do_act  = 1'b0;
    do_cas  = 1'b0;
    fin     = 1'b0;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_CHECK;
      S_CHECK: begin
        if (open_q[bank] && row_tab_q[bank] == row_q) state_d = S_CAS;
`ifdef CLOSED_PAGE_EN
        else state_d = S_ACT;
`else
        else if (!open_q[bank]) state_d = S_ACT;
        // tRAS counter reaches zero on this edge, so PRE lands T_RAS+1 after ACT
        else if (tras_q[bank] <= 8'd1) state_d = S_PRE;
`endif
      end
      S_PRE:   do_pre = 1'b1;
      S_ACT:   do_act = 1'b1;
      S_CAS:   do_cas = 1'b1;
      S_WAIT_RP: begin
        if (wait_q == 8'd0) do_act = 1'b1;
        else wait_d = wait_q - 8'd1;
      end
      S_WAIT_RCD: begin
        if (wait_q == 8'd0) do_cas = 1'b1;
        else wait_d = wait_q - 8'd1;
      end
      S_WAIT_DATA: begin
        if (wait_q == 8'd0) begin
          fin     = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (do_pre) begin
      state_d = S_WAIT_RP;
      wait_d  = RP_LOAD;
    end
    if (do_act) begin
      state_d = S_WAIT_RCD;
      wait_d  = RCD_LOAD;
    end
    if (do_cas) begin
      state_d = S_WAIT_DATA;
      wait_d  = (op_q == 2'd1) ? WR_LOAD : RD_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wait_q      <= 8'd0;
      op_q        <= 2'd0;
      bg_q        <= 3'd0;
      ba_q        <= 2'd0;
      row_q       <= 16'd0;
      col_q       <= 10'd0;
      open_q      <= 32'd0;
      req_ready_q <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_type_q  <= CMD_NOP;
      cmd_bg_q    <= 3'd0;
      cmd_ba_q    <= 2'd0;
      cmd_row_q   <= 16'd0;
      cmd_col_q   <= 10'd0;
      done_q      <= 1'b0;
      done_op_q   <= 2'd0;
      for (int i = 0; i < 32; i++) begin
        row_tab_q[i] <= 16'd0;
        tras_q[i]    <= 8'd0;
      end
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      req_ready_q <= (state_q == S_IDLE) && !accept;
      if (accept) begin
        op_q  <= bus_io.req_op;
        bg_q  <= bus_io.req_addr[9:7];
        ba_q  <= bus_io.req_addr[11:10];
        row_q <= bus_io.req_addr[33:18];
        col_q <= {bus_io.req_addr[17:12], bus_io.req_addr[5:2]};
      end

      for (int i = 0; i < 32; i++) begin
        if (tras_q[i] != 8'd0) tras_q[i] <= tras_q[i] - 8'd1;
      end

      cmd_valid_q <= do_pre | do_act | do_cas;
      cmd_type_q  <= CMD_NOP;
      if (do_pre | do_act | do_cas) begin
        cmd_bg_q  <= bg_q;
        cmd_ba_q  <= ba_q;
        cmd_row_q <= row_q;
        cmd_col_q <= col_q;
      end
      if (do_pre) begin
        cmd_type_q   <= CMD_PRE;
        open_q[bank] <= 1'b0;
      end
      if (do_act) begin
        cmd_type_q      <= CMD_ACT;
        open_q[bank]    <= 1'b1;
        row_tab_q[bank] <= row_q;
        tras_q[bank]    <= RAS_LOAD;
      end
      if (do_cas) begin
        cmd_type_q <= (op_q == 2'd1) ? CMD_WR : CMD_RD;
`ifdef CLOSED_PAGE_EN
        open_q[bank] <= 1'b0;
`endif
      end

      done_q <= fin;
      if (fin) done_op_q <= op_q;
    end
  end

  assign bus_io.req_ready = req_ready_q;
  assign bus_io.cmd_valid = cmd_valid_q;
  assign bus_io.cmd_type  = cmd_type_q;
  assign bus_io.cmd_bg    = cmd_bg_q;
  assign bus_io.cmd_ba    = cmd_ba_q;
  assign bus_io.cmd_row   = cmd_row_q;
  assign bus_io.cmd_col   = cmd_col_q;
  assign bus_io.done      = done_q;
  assign bus_io.done_op   = done_op_q;

endmodule
